// File: rtl/sprite_commit_scheduler.sv
// Vblank-synchronised commit scheduler: replays dirty sprite shadow entries one per clock from the next vblank rise.
// Optional macro SPRITE_COMMIT_VBLANK_SYNC_EN adds a 2-flop synchroniser on vblank for a foreign video clock.
module sprite_commit_scheduler #(
    parameter int PLANES      = 7,
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_we,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [1:0]                   cpu_sel,
    input  logic signed [DATA_WIDTH-1:0] cpu_data,
    input  logic                         commit_req,
    input  logic                         vblank,
    output logic                         commit_pending,
    output logic                         commit_busy,
    output logic                         spr_we,
    output logic [ADDR_WIDTH-1:0]        spr_addr,
    output logic signed [DATA_WIDTH-1:0] spr_x,
    output logic signed [DATA_WIDTH-1:0] spr_y,
    output logic                         spr_en,
    output logic [FRAME_WIDTH-1:0]       frame_count,
    output logic [1:0]                   dbg_state
);

    // Handshake: cpu_we is a single-cycle write strobe (no ready), commit_req a one-cycle
    // pulse, and spr_we a one-cycle strobe qualifying spr_addr/spr_x/spr_y/spr_en.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PLANES - 1);
    localparam logic [ADDR_WIDTH:0]   PLANES_W = (ADDR_WIDTH + 1)'(PLANES);

    state_t                         state;
    logic [ADDR_WIDTH-1:0]          idx;
    logic                           req_latched;
    logic [PLANES-1:0]              dirty;
    logic signed [DATA_WIDTH-1:0]   shadow_x [PLANES];
    logic signed [DATA_WIDTH-1:0]   shadow_y [PLANES];
    logic [PLANES-1:0]              shadow_en;
    logic                           vblank_src;
    logic                           vblank_d;
    logic                           rise;
    logic                           wr_ok;

    assign dbg_state = state;

`ifdef SPRITE_COMMIT_VBLANK_SYNC_EN
    logic vblank_s1;
    logic vblank_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_s1 <= 1'b0;
            vblank_s2 <= 1'b0;
        end else begin
            vblank_s1 <= vblank;
            vblank_s2 <= vblank_s1;
        end
    end

    assign vblank_src = vblank_s2;
`else
    assign vblank_src = vblank;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_d <= 1'b0;
        end else begin
            vblank_d <= vblank_src;
        end
    end

    assign rise  = vblank_src & ~vblank_d;
    assign wr_ok = cpu_we && ({1'b0, cpu_addr} < PLANES_W) && (cpu_sel != 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            req_latched    <= 1'b0;
            dirty          <= '0;
            shadow_en      <= '0;
            commit_pending <= 1'b0;
            commit_busy    <= 1'b0;
            spr_we         <= 1'b0;
            spr_addr       <= '0;
            spr_x          <= '0;
            spr_y          <= '0;
            spr_en         <= 1'b0;
            frame_count    <= '0;
            for (int i = 0; i < PLANES; i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
            end
        end else begin
            spr_we <= 1'b0;

            // Emission reads the shadow before this cycle's CPU write lands; a write to the
            // same index re-sets dirty below so the new value rides the next commit.
            if (state == COMMIT && dirty[idx]) begin
                spr_we     <= 1'b1;
                spr_addr   <= idx;
                spr_x      <= shadow_x[idx];
                spr_y      <= shadow_y[idx];
                spr_en     <= shadow_en[idx];
                dirty[idx] <= 1'b0;
            end

            if (wr_ok) begin
                case (cpu_sel)
                    2'd0:    shadow_x[cpu_addr]  <= cpu_data;
                    2'd1:    shadow_y[cpu_addr]  <= cpu_data;
                    default: shadow_en[cpu_addr] <= cpu_data[0];
                endcase
                dirty[cpu_addr] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (commit_req) begin
                        state          <= ARMED;
                        commit_pending <= 1'b1;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        state          <= COMMIT;
                        commit_pending <= 1'b0;
                        commit_busy    <= 1'b1;
                        idx            <= '0;
                    end
                end
                COMMIT: begin
                    if (commit_req) begin
                        req_latched <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state       <= DONE;
                        commit_busy <= 1'b0;
                    end else begin
                        idx <= idx + ADDR_WIDTH'(1);
                    end
                end
                DONE: begin
                    frame_count <= frame_count + FRAME_WIDTH'(1);
                    req_latched <= 1'b0;
                    if (req_latched || commit_req) begin
                        state          <= ARMED;
                        commit_pending <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_commit_scheduler.sv
// Directed bench for sprite_commit_scheduler (default build, vblank used directly) with a
// rule-level reference model compared every cycle plus literal expectations per scenario.
module tb_sprite_commit_scheduler;

    localparam int PLANES = 7;
    localparam int AW     = 3;
    localparam int DW     = 32;
    localparam int FW     = 16;

    logic                 clk        = 1'b0;
    logic                 reset      = 1'b1;
    logic                 cpu_we     = 1'b0;
    logic [AW-1:0]        cpu_addr   = '0;
    logic [1:0]           cpu_sel    = '0;
    logic signed [DW-1:0] cpu_data   = '0;
    logic                 commit_req = 1'b0;
    logic                 vblank     = 1'b0;
    logic                 commit_pending;
    logic                 commit_busy;
    logic                 spr_we;
    logic [AW-1:0]        spr_addr;
    logic signed [DW-1:0] spr_x;
    logic signed [DW-1:0] spr_y;
    logic                 spr_en;
    logic [FW-1:0]        frame_count;
    logic [1:0]           dbg_state;

    always #5 clk = ~clk;

    sprite_commit_scheduler #(
        .PLANES(PLANES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_WIDTH(FW)
    ) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_data(cpu_data), .commit_req(commit_req), .vblank(vblank),
        .commit_pending(commit_pending), .commit_busy(commit_busy), .spr_we(spr_we),
        .spr_addr(spr_addr), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
        .frame_count(frame_count), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [67:0] exp_q[$];

    // Reference model: shadow contents, dirty flags and replay position as plain variables.
    logic [DW-1:0] m_x [PLANES];
    logic [DW-1:0] m_y [PLANES];
    logic          m_en [PLANES];
    logic          m_dirty [PLANES];
    logic          m_vb_prev;
    logic          m_pending;
    logic          m_latch;
    int            m_pos;
    logic [FW-1:0] m_frame;
    logic          exp_we;

    int            cyc = 0;
    int            rise_cyc = 0;
    int            n_strobes = 0;
    int            first_cyc = 0;
    int            last_cyc = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_x;
    logic [DW-1:0] last_y;
    logic          last_en;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < PLANES; i++) begin
            m_x[i] = '0; m_y[i] = '0; m_en[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        m_vb_prev = 1'b0;
        m_pending = 1'b0;
        m_latch   = 1'b0;
        m_pos     = -1;
        m_frame   = '0;
        exp_we    = 1'b0;
    endtask

    // m_pos: -1 not replaying, 0..PLANES-1 index examined this cycle, PLANES = wrap-up cycle.
    task automatic model_step();
        logic rise;
        exp_we = 1'b0;
        if (m_pos >= 0 && m_pos < PLANES && m_dirty[m_pos]) begin
            exp_we = 1'b1;
            exp_q.push_back({AW'(m_pos), m_x[m_pos], m_y[m_pos], m_en[m_pos]});
            m_dirty[m_pos] = 1'b0;
        end
        if (cpu_we && int'(cpu_addr) < PLANES && cpu_sel != 2'd3) begin
            if (cpu_sel == 2'd0) m_x[cpu_addr] = cpu_data;
            else if (cpu_sel == 2'd1) m_y[cpu_addr] = cpu_data;
            else m_en[cpu_addr] = cpu_data[0];
            m_dirty[cpu_addr] = 1'b1;
        end
        rise = vblank && !m_vb_prev;
        if (m_pos == PLANES) begin
            m_frame++;
            m_pos     = -1;
            m_pending = m_latch || commit_req;
            m_latch   = 1'b0;
        end else if (m_pos >= 0) begin
            if (commit_req) m_latch = 1'b1;
            m_pos++;
        end else if (m_pending) begin
            if (rise) begin
                m_pending = 1'b0;
                m_pos     = 0;
                rise_cyc  = cyc;
            end
        end else if (commit_req) begin
            m_pending = 1'b1;
        end
        m_vb_prev = vblank;
    endtask

    // Compare process: advance the model at each edge, check the DUT 1 ns later.
    initial begin
        logic [67:0] w;
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
            end
            #1;
            check("commit_pending", commit_pending, m_pending);
            check("commit_busy", commit_busy, (m_pos >= 0 && m_pos < PLANES));
            check("spr_we", spr_we, exp_we);
            check("frame_count", frame_count, m_frame);
            if (spr_we === 1'b1) begin
                n_strobes++;
                if (n_strobes == 1) first_cyc = cyc;
                last_cyc  = cyc;
                last_addr = spr_addr;
                last_x    = spr_x;
                last_y    = spr_y;
                last_en   = spr_en;
                check("strobe_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("strobe_data", {spr_addr, spr_x, spr_y, spr_en}, w);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = a; cpu_sel = s; cpu_data = d;
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
    endtask

    task automatic vblank_pulse();
        @(negedge clk);
        vblank = 1'b1;
        idle(12);
        vblank = 1'b0;
        idle(2);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_spr_we", spr_we, 1'b0);
        check("rst_frame", frame_count, 16'd0);
        check("rst_pending", commit_pending, 1'b0);
        check("rst_busy", commit_busy, 1'b0);
        check("rst_spr_x", spr_x, 32'd0);
        reset = 1'b0;
        idle(2);

        // Single dirty entry, latency pinned
        do_write(3'd2, 2'd0, 32'd100);
        do_write(3'd2, 2'd1, -32'sd5);
        do_write(3'd2, 2'd2, 32'd1);
        pulse_commit();
        idle(3);
        check("t1_pending_wait", commit_pending, 1'b1);
        n_strobes = 0;
        vblank_pulse();
        check("t1_count", n_strobes, 1);
        check("t1_addr", last_addr, 3'd2);
        check("t1_x", last_x, 32'd100);
        check("t1_y", last_y, 32'hFFFF_FFFB);
        check("t1_en", last_en, 1'b1);
        check("t1_latency", first_cyc - rise_cyc, 3);
        check("t1_frame", frame_count, 16'd1);

        // All dirty, then a commit with nothing dirty
        for (int i = 0; i < PLANES; i++) begin
            do_write(AW'(i), 2'd0, DW'(i * 10 + 1));
            do_write(AW'(i), 2'd1, -DW'(i));
            do_write(AW'(i), 2'd2, DW'(i & 1));
        end
        pulse_commit();
        n_strobes = 0;
        vblank_pulse();
        check("t2_count", n_strobes, 7);
        check("t2_span", last_cyc - first_cyc, 6);
        check("t2_first_lat", first_cyc - rise_cyc, 1);
        check("t2_last_addr", last_addr, 3'd6);
        check("t2_last_x", last_x, 32'd61);
        pulse_commit();
        n_strobes = 0;
        vblank_pulse();
        check("t2_empty_count", n_strobes, 0);
        check("t2_frame", frame_count, 16'd3);

        // commit_req while vblank already high waits for the next rise
        do_write(3'd0, 2'd0, 32'd55);
        @(negedge clk);
        vblank = 1'b1;
        idle(2);
        n_strobes = 0;
        pulse_commit();
        idle(5);
        check("t3_pending", commit_pending, 1'b1);
        check("t3_no_strobe", n_strobes, 0);
        vblank = 1'b0;
        idle(2);
        vblank_pulse();
        check("t3_count", n_strobes, 1);
        check("t3_addr", last_addr, 3'd0);
        check("t3_x", last_x, 32'd55);

        // CPU write collides with emission of the same index
        do_write(3'd3, 2'd0, 32'd1);
        pulse_commit();
        n_strobes = 0;
        @(negedge clk);
        vblank = 1'b1;
        repeat (4) @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 3'd3; cpu_sel = 2'd0; cpu_data = 32'd7;
        @(negedge clk);
        cpu_we = 1'b0;
        idle(10);
        vblank = 1'b0;
        idle(2);
        check("t4_count", n_strobes, 1);
        check("t4_old_x", last_x, 32'd1);
        pulse_commit();
        n_strobes = 0;
        vblank_pulse();
        check("t4_next_count", n_strobes, 1);
        check("t4_next_addr", last_addr, 3'd3);
        check("t4_new_x", last_x, 32'd7);

        // commit_req during replay re-arms after it finishes
        do_write(3'd1, 2'd0, 32'd11);
        pulse_commit();
        n_strobes = 0;
        @(negedge clk);
        vblank = 1'b1;
        idle(2);
        pulse_commit();
        idle(10);
        check("t5_rearmed", commit_pending, 1'b1);
        check("t5_frame_mid", frame_count, 16'd7);
        vblank = 1'b0;
        do_write(3'd5, 2'd1, 32'd500);
        idle(2);
        vblank_pulse();
        check("t5_count", n_strobes, 2);
        check("t5_addr", last_addr, 3'd5);
        check("t5_y", last_y, 32'd500);
        check("t5_frame", frame_count, 16'd8);

        // Reset in the middle of a replay
        for (int i = 0; i < PLANES; i++) do_write(AW'(i), 2'd0, DW'(i + 200));
        pulse_commit();
        n_strobes = 0;
        @(negedge clk);
        vblank = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_we_now", spr_we, 1'b0);
        check("t6_frame_now", frame_count, 16'd0);
        check("t6_busy_now", commit_busy, 1'b0);
        check("t6_count", n_strobes, 3);
        @(negedge clk);
        reset = 1'b0;
        vblank = 1'b0;
        idle(3);
        n_strobes = 0;
        vblank_pulse();
        check("t6_quiet", n_strobes, 0);
        do_write(3'd7, 2'd0, 32'd9);
        do_write(3'd0, 2'd3, 32'd9);
        pulse_commit();
        vblank_pulse();
        check("t6_ignored_writes", n_strobes, 0);
        check("t6_frame", frame_count, 16'd1);

        idle(2);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
